regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file for the SEQ/PIPE Y86-64 cores.
//   - Two combinational read ports (srcA/srcB) and two clocked write ports:
//     dstE carries the ALU result, dstM carries the memory result.
//   - Synchronous reset; optional write-through bypass; one debug read port.
//   - Sits between decode (reads) and write-back (writes).
// PARAMETERS
//   DATA_W    64      width of each register and data port
//   NUM_REGS  15      implemented registers, indices 0..NUM_REGS-1
//   ADDR_W    4       register-index width; must satisfy 2**ADDR_W > NUM_REGS
//   RNONE     4'hF    "no register" index; must be >= NUM_REGS
//   SP_IDX    4       index of %rsp
//   SP_INIT   0       %rsp value loaded at reset
//   BYPASS    1       1: same-cycle write is visible on the read ports; 0: old value is read
// PORTS
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous reset, active high
//   srcA     in   ADDR_W   read index, port A
//   srcB     in   ADDR_W   read index, port B
//   valA     out  DATA_W   read data, port A (combinational)
//   valB     out  DATA_W   read data, port B (combinational)
//   dstE     in   ADDR_W   write index, E port (RNONE = no write)
//   valE     in   DATA_W   write data, E port
//   dstM     in   ADDR_W   write index, M port (RNONE = no write)
//   valM     in   DATA_W   write data, M port
//   wr_en    in   1        global write enable; 0 suppresses both writes (stall)
//   dbg_sel  in   ADDR_W   debug read index
//   dbg_val  out  DATA_W   registered debug data: value of reg[dbg_sel] at the last edge
// BEHAVIOUR
//   Reset (rst=1 at posedge clk)
//   - Every reg[i] := 0, except reg[SP_IDX] := SP_INIT.
//   - dbg_val := 0.
//   - All writes in that cycle are discarded; reset wins over any write.
//   Index validity
//   - An index is valid when it is < NUM_REGS.
//   - Invalid indices, including RNONE, read as 0 and are never written.
//   Write (posedge clk, rst=0, wr_en=1)
//   - If dstE is valid: reg[dstE] := valE.
//   - If dstM is valid: reg[dstM] := valM.
//   - If dstE == dstM (valid): valM wins, so popq %rsp leaves the popped value.
//   - wr_en=0: no register changes.
//   Read (combinational)
//   - valX = reg[srcX] for X in {A, B}.
//   - If BYPASS=1, wr_en=1 and rst=0, the read returns the incoming write data:
//     - valM when srcX == dstM (valid).
//     - else valE when srcX == dstE (valid).
//     - The priority order matches the write rule.
//   - If BYPASS=0, the read always returns the stored value.
//   - Read latency is 0 cycles; write-to-storage latency is 1 edge.
//   Debug port
//   - dbg_val := (dbg_sel valid) ? reg_next[dbg_sel] : 0, registered each edge.
//   - reg_next is the post-write value, so dbg_val shows the state after the edge.
//   Width rules
//   - No arithmetic is performed; data passes through unmodified.
//   - Signed interpretation belongs to the consumer.
//   Mid-operation reset
//   - Asserting rst in any cycle clears state at that edge regardless of
//     dst/src/wr_en.
//   - During rst=1, reads see the pre-reset stored values; the bypass is disabled.
// TESTING
//   - Reset: rst=1 for 1 edge, SP_INIT=64'h200 -> every reg reads 0,
//     reg4 reads 64'h200, dbg_val=0.
//   - Basic write: dstE=3, valE=64'd42, dstM=RNONE, wr_en=1, 1 edge
//     -> srcA=3 gives valA=42; srcB=RNONE gives valB=0.
//   - Conflict: dstE=4, valE=64'h1F8, dstM=4, valM=64'hABCD, 1 edge
//     -> reg4=64'hABCD.
//   - Bypass (BYPASS=1): srcA=dstE=2, valE=64'd7 in the same cycle -> valA=7
//     before the edge. With BYPASS=0 -> old value, then 7 after the edge.
//   - Stall: wr_en=0, dstE=1, valE=64'hDEAD, 3 edges -> reg1 unchanged,
//     bypass inactive.
//   - Reset mid-stream: after reg5=9, assert rst together with dstE=5,
//     valE=64'd11 -> reg5=0 after the edge.
//     Random write/read sweep vs a reference model for 1000 cycles
//     -> no mismatch.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file for the Y86-64 SEQ/PIPE cores.
// Two combinational read ports, two clocked write ports (E = ALU result,
// M = memory result) and a registered debug read port. When both write
// ports target the same register, M wins so that popq %rsp keeps the
// popped value. The optional bypass forwards same-cycle write data to the
// read ports using that same M-over-E priority.
module regfile_mp #(
    parameter int                 DATA_W   = 64,
    parameter int                 NUM_REGS = 15,
    parameter int                 ADDR_W   = 4,
    parameter logic [ADDR_W-1:0]  RNONE    = '1,
    parameter int                 SP_IDX   = 4,
    parameter logic [DATA_W-1:0]  SP_INIT  = '0,
    parameter bit                 BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS);

    function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
        return (idx < NREGS_A) && (idx != RNONE);
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] dbg_val_q;
    logic [DATA_W-1:0] dbg_val_d;
    logic              we_e;
    logic              we_m;
    logic              byp_on;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    // Qualified write strobes; invalid indices (incl. RNONE) never write.
    always_comb begin
        we_e = wr_en && idx_valid(dstE);
        we_m = wr_en && idx_valid(dstM);
    end

    // Post-write register image: E applied first so M overrides on conflict.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_e && (dstE == ADDR_W'(i))) regs_d[i] = valE;
            if (we_m && (dstM == ADDR_W'(i))) regs_d[i] = valM;
        end
    end

    // Debug data follows the post-write image; unmatched indices give 0.
    always_comb begin
        dbg_val_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dbg_sel == ADDR_W'(i)) dbg_val_d = regs_d[i];
        end
    end

    // Storage and debug register; reset overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            dbg_val_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dbg_val_q <= dbg_val_d;
        end
    end

    // Combinational reads with optional forwarding (disabled during reset/stall).
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (srcA == ADDR_W'(i)) stored_a = regs_q[i];
            if (srcB == ADDR_W'(i)) stored_b = regs_q[i];
        end
        byp_on = BYPASS && wr_en && !rst;

        valA = stored_a;
        if (byp_on && we_m && (srcA == dstM))      valA = valM;
        else if (byp_on && we_e && (srcA == dstE)) valA = valE;

        valB = stored_b;
        if (byp_on && we_m && (srcB == dstM))      valB = valM;
        else if (byp_on && we_e && (srcB == dstE)) valB = valE;
    end

    assign dbg_val = dbg_val_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one instance with bypass, one without,
// sharing the same stimulus. The driver pushes expected read/debug values
// computed from an array model; the monitor pops and compares mid-cycle.
module tb_regfile_mp;

    localparam logic [63:0] SP_INIT_V = 64'h200;
    localparam logic [3:0]  RN        = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, dbg_sel;
    logic [63:0] valE, valM;
    logic        wr_en;
    logic [63:0] valA1, valB1, dbg1;
    logic [63:0] valA0, valB0, dbg0;

    always #5 clk = ~clk;

    regfile_mp #(.SP_INIT(SP_INIT_V), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wr_en(wr_en),
        .dbg_sel(dbg_sel), .dbg_val(dbg1)
    );

    regfile_mp #(.SP_INIT(SP_INIT_V), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wr_en(wr_en),
        .dbg_sel(dbg_sel), .dbg_val(dbg0)
    );

    typedef struct {
        bit          en;
        logic [63:0] a1, b1, a0, b0, dbg;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] m [16];
    logic [63:0] dbg_m = '0;

    task automatic chk(input string name, input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Reference read: stored value, or the incoming write data when forwarding.
    function automatic logic [63:0] ref_read(input logic [3:0] s, input bit byp,
                                             input bit r, input bit we,
                                             input logic [3:0] de, input logic [63:0] ve,
                                             input logic [3:0] dm, input logic [63:0] vm);
        if (byp && we && !r) begin
            if (dm < 15 && s == dm) return vm;
            if (de < 15 && s == de) return ve;
        end
        return (s < 15) ? m[s] : 64'd0;
    endfunction

    task automatic cycle(input bit r, input logic [3:0] sa, input logic [3:0] sbi,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input bit we, input logic [3:0] ds, input bit en, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; srcA = sa; srcB = sbi; dstE = de; valE = ve;
        dstM = dm; valM = vm; wr_en = we; dbg_sel = ds;
        e.en  = en;
        e.tag = tag;
        e.a1  = ref_read(sa,  1'b1, r, we, de, ve, dm, vm);
        e.b1  = ref_read(sbi, 1'b1, r, we, de, ve, dm, vm);
        e.a0  = ref_read(sa,  1'b0, r, we, de, ve, dm, vm);
        e.b0  = ref_read(sbi, 1'b0, r, we, de, ve, dm, vm);
        e.dbg = dbg_m;
        sb_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 16; i++) m[i] = 64'd0;
            m[4]  = SP_INIT_V;
            dbg_m = 64'd0;
        end else begin
            if (we) begin
                if (de < 15) m[de] = ve;
                if (dm < 15) m[dm] = vm;
            end
            dbg_m = (ds < 15) ? m[ds] : 64'd0;
        end
    endtask

    // Monitor: outputs are settled mid-cycle; compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.en) begin
                    chk("valA_byp",   e.tag, valA1, e.a1);
                    chk("valB_byp",   e.tag, valB1, e.b1);
                    chk("valA_nobyp", e.tag, valA0, e.a0);
                    chk("valB_nobyp", e.tag, valB0, e.b0);
                    chk("dbg_byp",    e.tag, dbg1,  e.dbg);
                    chk("dbg_nobyp",  e.tag, dbg0,  e.dbg);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m[i] = 64'd0;
        rst = 1'b1; srcA = '0; srcB = '0; dstE = RN; dstM = RN;
        valE = '0; valM = '0; wr_en = 1'b0; dbg_sel = '0;

        cycle(1, 0, 0, RN, 0, RN, 0, 0, 0, 0, "reset");
        cycle(0, 4, 0, RN, 0, RN, 0, 0, 4, 1, "after_reset");
        cycle(0, 1, 14, RN, 0, RN, 0, 0, 0, 1, "after_reset_others");
        cycle(0, 3, RN, 3, 64'd42, RN, 0, 1, 3, 1, "basic_write");
        cycle(0, 3, RN, RN, 0, RN, 0, 0, 3, 1, "basic_readback");
        cycle(0, 4, 4, 4, 64'h1F8, 4, 64'hABCD, 1, 4, 1, "conflict");
        cycle(0, 4, 3, RN, 0, RN, 0, 0, 4, 1, "conflict_readback");
        cycle(0, 2, 5, 2, 64'd7, RN, 0, 1, 2, 1, "bypass");
        cycle(0, 2, 2, RN, 0, RN, 0, 0, RN, 1, "bypass_after");
        cycle(0, 1, 1, 1, 64'hDEAD, RN, 0, 0, 1, 1, "stall1");
        cycle(0, 1, 1, 1, 64'hDEAD, RN, 0, 0, 1, 1, "stall2");
        cycle(0, 1, 1, 1, 64'hDEAD, RN, 0, 0, 1, 1, "stall3");
        cycle(0, 1, RN, RN, 0, RN, 0, 0, 1, 1, "stall_readback");
        cycle(0, 5, 5, RN, 0, 5, 64'd9, 1, 5, 1, "set_reg5");
        cycle(0, 5, 5, 5, 64'd11, RN, 0, 0, 5, 1, "pre_rst_read");
        cycle(1, 5, 4, 5, 64'd11, RN, 0, 1, 5, 1, "rst_with_write");
        cycle(0, 5, 4, RN, 0, RN, 0, 0, 5, 1, "post_rst_read");

        for (int n = 0; n < 1000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)),
                  1, "random");
        end

        repeat (4) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
